deadtime_gen: RTL and testbench
===============================

# deadtime_gen

Downstream gate-drive stage for the fixed-frequency driver. Converts the two leg commands (drv0/drv1 and their enables) into four complementary high-side/low-side gate signals for two half-bridge legs. Inserts a programmable both-off deadtime on every transition and forces all gates off on a synchronised external fault. All gate outputs are registered.

## Interface
- DEADTIME_BITS, 8, width of the deadtime value in clk cycles
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- deadtime  in  DEADTIME_BITS  requested deadtime in cycles
- deadtime_load  in  1  one-cycle pulse; samples `deadtime` into the active register
- leg0_cmd  in  1  leg 0 command (1 = high side on, 0 = low side on); connects to drv0
- leg0_en  in  1  leg 0 enable; connects to drv0_en
- leg1_cmd  in  1  leg 1 command; connects to drv1
- leg1_en  in  1  leg 1 enable; connects to drv1_en
- fault_in  in  1  asynchronous external fault, active high
- fault_clr  in  1  one-cycle pulse; clears the latched fault (used only with DRV_FAULT_LATCH_EN)
- leg0_hi, leg0_lo  out  1  leg 0 gate drives
- leg1_hi, leg1_lo  out  1  leg 1 gate drives
- dead_active  out  2  bit i is 1 while leg i is in a dead state
- fault_active  out  1  the fault is currently forcing all gates off

## Operation
- Reset values: all gate outputs 0, dead_active 0, fault_active 0, active deadtime 0, both legs in OFF.
- Active deadtime `dt` is updated only by `deadtime_load`. It takes effect at the next entry into a dead state. A count already running is not disturbed.
- Effective dead length is D = max(dt, 1) cycles. With dt = 0, there is still one both-off cycle.
- Each leg has an identical, independent state machine with states OFF, DEAD_H, HI, DEAD_L, LO:
  - **OFF** (hi=0, lo=0): if en=1 and no fault, go to DEAD_H when cmd=1, otherwise go to DEAD_L.
  - **DEAD_H** (0,0): the counter loads D on entry and decrements.
    - When the count expires, go to HI.
    - If cmd falls before expiry, go directly to LO. Neither side was on, so no deadtime is owed.
  - **HI** (1,0): if cmd=0, go to DEAD_L.
  - **DEAD_L** (0,0): mirror of DEAD_H.
    - When the count expires, go to LO.
    - If cmd rises before expiry, go directly to HI.
  - **LO** (0,1): if cmd=1, go to DEAD_H.
- From any state, en=0 or fault_active=1 sends the leg to OFF on the next edge. This has priority over every other transition.
- hi and lo are never 1 together. An assertion checks this under `ifdef SIMULATION`.
- Fault path:
  - fault_in passes through a 2-flop synchroniser (sync flops are reset to 0).
  - Synchronised high sets fault_active.
  - Clearing depends on the configuration macro.

## Timing
- Command to gate latency, with cmd sampled high at edge t while the leg is in LO:
  - lo=0 after edge t.
  - hi=1 after edge t+D.
  - The high-to-low transition is symmetric.
- Enable: en falling at edge t forces gates to 0 after edge t. en rising at edge t means the first gate turns on after edge t+1+D.
- Fault: fault_in asserted asynchronously sets fault_active and forces gates to 0 within 3 clk edges.
- Simultaneous events:
  - deadtime_load in the same cycle as a dead-state entry uses the old `dt`.
  - fault wins over en, and en wins over cmd.
- Reset asserted mid-operation clears all gates asynchronously, immediately, without waiting for clk.

## Configuration
- `DRV_FAULT_LATCH_EN` defined:
  - fault_active is sticky once set.
  - It clears only on a fault_clr pulse while synchronised fault_in is 0. A fault_clr pulse while the fault persists is ignored.
  - Legs then restart from OFF through a dead state.
- `DRV_FAULT_LATCH_EN` undefined:
  - fault_active follows synchronised fault_in.
  - fault_clr is ignored.

## Test plan
- **Deadtime on both edges.** Load dt=5, en=1, toggle cmd with 40-cycle high and low phases. Require lo falling to hi rising = 5 cycles, hi falling to lo rising = 5 cycles, and hi&lo never both 1.
- **Short pulse.** dt=10, LO state, cmd high for 3 cycles. Require hi to stay 0 throughout, the leg to return to LO with lo=1 the cycle after cmd falls, and dead_active high for 3 cycles.
- **Zero deadtime.** Load dt=0 and toggle cmd. Require exactly one both-off cycle per transition.
- **Mid-count load.** dt=8 while in DEAD_H, load dt=2 at count 4. Require the current dead state to last 8 cycles and the next transition to use 2.
- **Fault, latched build.** Pulse fault_in for 1 cycle while in HI. Require all gates 0 within 3 cycles and fault_active to hold. Require fault_clr to clear it and lo to reassert D cycles after the clear edge. On a build without the macro, require recovery without fault_clr.
- **Async reset.** Assert rst_n low mid-HI. Require gates 0 immediately, then recovery via OFF to DEAD_* after release.

Source files
------------

// File: rtl/deadtime_gen.sv
// Two-leg half-bridge gate driver with programmable both-off deadtime and fault shutdown.
// Define DRV_FAULT_LATCH_EN to make fault_active sticky until a fault_clr pulse.
module deadtime_gen #(
  parameter int DEADTIME_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DEADTIME_BITS-1:0] deadtime,
  input  logic                     deadtime_load,
  input  logic                     leg0_cmd,
  input  logic                     leg0_en,
  input  logic                     leg1_cmd,
  input  logic                     leg1_en,
  input  logic                     fault_in,
  input  logic                     fault_clr,
  output logic                     leg0_hi,
  output logic                     leg0_lo,
  output logic                     leg1_hi,
  output logic                     leg1_lo,
  output logic [1:0]               dead_active,
  output logic                     fault_active
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DEAD_H,
    ST_HI,
    ST_DEAD_L,
    ST_LO
  } leg_state_t;

  localparam logic [DEADTIME_BITS-1:0] CNT_ONE = DEADTIME_BITS'(1);

  logic [DEADTIME_BITS-1:0] dt_reg;
  logic [DEADTIME_BITS-1:0] dead_len;
  logic                     fault_meta_reg;
  logic                     fault_sync_reg;
  logic                     fault_active_reg;
  logic                     fault_next;
  logic [1:0]               cmd_vec;
  logic [1:0]               en_vec;
  logic [1:0]               hi_vec;
  logic [1:0]               lo_vec;
  logic [1:0]               dead_vec;

  assign cmd_vec = {leg1_cmd, leg0_cmd};
  assign en_vec  = {leg1_en, leg0_en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_reg <= '0;
    end else if (deadtime_load) begin
      dt_reg <= deadtime;
    end
  end

  // A zero deadtime still yields one both-off cycle.
  assign dead_len = (dt_reg == '0) ? CNT_ONE : dt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta_reg   <= 1'b0;
      fault_sync_reg   <= 1'b0;
      fault_active_reg <= 1'b0;
    end else begin
      fault_meta_reg   <= fault_in;
      fault_sync_reg   <= fault_meta_reg;
      fault_active_reg <= fault_next;
    end
  end

`ifdef DRV_FAULT_LATCH_EN
  // Sticky: a clear only succeeds once the synchronised fault has gone away.
  assign fault_next = fault_sync_reg | (fault_active_reg & ~fault_clr);
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault_next       = fault_sync_reg;
`endif

  assign fault_active = fault_active_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_leg
      leg_state_t               state_reg, state_next;
      logic [DEADTIME_BITS-1:0] cnt_reg, cnt_next;
      logic                     hi_reg, lo_reg, dead_reg;
      logic                     expire;

      assign expire = (cnt_reg <= CNT_ONE);

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        // Fault and disable pre-empt every other transition.
        if (!en_vec[gi] || fault_next) begin
          state_next = ST_OFF;
        end else begin
          case (state_reg)
            ST_OFF: begin
              state_next = cmd_vec[gi] ? ST_DEAD_H : ST_DEAD_L;
              cnt_next   = dead_len;
            end
            ST_DEAD_H: begin
              if (!cmd_vec[gi]) begin
                state_next = ST_LO;
              end else if (expire) begin
                state_next = ST_HI;
              end else begin
                cnt_next = cnt_reg - CNT_ONE;
              end
            end
            ST_HI: begin
              if (!cmd_vec[gi]) begin
                state_next = ST_DEAD_L;
                cnt_next   = dead_len;
              end
            end
            ST_DEAD_L: begin
              if (cmd_vec[gi]) begin
                state_next = ST_HI;
              end else if (expire) begin
                state_next = ST_LO;
              end else begin
                cnt_next = cnt_reg - CNT_ONE;
              end
            end
            ST_LO: begin
              if (cmd_vec[gi]) begin
                state_next = ST_DEAD_H;
                cnt_next   = dead_len;
              end
            end
            default: state_next = ST_OFF;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= ST_OFF;
          cnt_reg   <= '0;
          hi_reg    <= 1'b0;
          lo_reg    <= 1'b0;
          dead_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          hi_reg    <= (state_next == ST_HI);
          lo_reg    <= (state_next == ST_LO);
          dead_reg  <= (state_next == ST_DEAD_H) || (state_next == ST_DEAD_L);
        end
      end

      assign hi_vec[gi]   = hi_reg;
      assign lo_vec[gi]   = lo_reg;
      assign dead_vec[gi] = dead_reg;

`ifdef SIMULATION
      a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n) !(hi_reg && lo_reg));
`endif
    end
  endgenerate

  assign leg0_hi     = hi_vec[0];
  assign leg0_lo     = lo_vec[0];
  assign leg1_hi     = hi_vec[1];
  assign leg1_lo     = lo_vec[1];
  assign dead_active = dead_vec;

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: directed timing checks, then a randomized scoreboard run
// against a side/wait-count reference model. Honors DRV_FAULT_LATCH_EN like the DUT.
module tb_deadtime_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] deadtime = '0;
  logic       deadtime_load = 1'b0;
  logic       leg0_cmd = 1'b0, leg0_en = 1'b0, leg1_cmd = 1'b0, leg1_en = 1'b0;
  logic       fault_in = 1'b0, fault_clr = 1'b0;
  logic       leg0_hi, leg0_lo, leg1_hi, leg1_lo;
  logic [1:0] dead_active;
  logic       fault_active;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       h0, l0, h1, l1;
    logic [1:0] dead;
    logic       fa;
  } exp_t;

  exp_t sb[$];

  deadtime_gen #(.DEADTIME_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .deadtime(deadtime), .deadtime_load(deadtime_load),
    .leg0_cmd(leg0_cmd), .leg0_en(leg0_en), .leg1_cmd(leg1_cmd), .leg1_en(leg1_en),
    .fault_in(fault_in), .fault_clr(fault_clr),
    .leg0_hi(leg0_hi), .leg0_lo(leg0_lo), .leg1_hi(leg1_hi), .leg1_lo(leg1_lo),
    .dead_active(dead_active), .fault_active(fault_active)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end else begin
      $display("check %s ok (%0d)", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which side is on (0 none, 1 hi, 2 lo), which side is wanted,
  // and how many edges remain before the wanted side may turn on.
  int m_dt;
  bit m_s1, m_s2, m_fa;
  bit m_run[2];
  int m_side[2];
  int m_want[2];
  int m_wait[2];

  task automatic model_reset();
    m_dt = 0; m_s1 = 0; m_s2 = 0; m_fa = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_side[i] = 0; m_want[i] = 0; m_wait[i] = 0;
    end
  endtask

  task automatic model_step(input bit c0, input bit e0, input bit c1, input bit e1,
                            input bit ld, input int dtv, input bit fin, input bit clr);
    int  dlen;
    bit  fa_new;
    bit  c[2];
    bit  e[2];
    int  want_side;
    exp_t x;
    c[0] = c0; c[1] = c1; e[0] = e0; e[1] = e1;
    dlen = (m_dt == 0) ? 1 : m_dt;
`ifdef DRV_FAULT_LATCH_EN
    fa_new = m_s2 | (m_fa & !clr);
`else
    fa_new = m_s2;
`endif
    for (int i = 0; i < 2; i++) begin
      want_side = c[i] ? 1 : 2;
      if (!e[i] || fa_new) begin
        m_run[i] = 0; m_side[i] = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1; m_side[i] = 0; m_want[i] = want_side; m_wait[i] = dlen;
      end else if (m_side[i] != 0) begin
        if (want_side != m_side[i]) begin
          m_side[i] = 0; m_want[i] = want_side; m_wait[i] = dlen;
        end
      end else if (want_side != m_want[i]) begin
        m_side[i] = want_side;
      end else begin
        m_wait[i]--;
        if (m_wait[i] == 0) m_side[i] = m_want[i];
      end
    end
    m_fa = fa_new;
    m_s2 = m_s1;
    m_s1 = fin;
    if (ld) m_dt = dtv;
    x.h0 = (m_side[0] == 1); x.l0 = (m_side[0] == 2);
    x.h1 = (m_side[1] == 1); x.l1 = (m_side[1] == 2);
    x.dead = {m_run[1] && m_side[1] == 0, m_run[0] && m_side[0] == 0};
    x.fa = m_fa;
    sb.push_back(x);
  endtask

  // Scoreboard monitor.
  int mon_cyc = 0;
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{h0: leg0_hi, l0: leg0_lo, h1: leg1_hi, l1: leg1_lo, dead: dead_active, fa: fault_active};
        checks++;
        mon_cyc++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d got {h0,l0,h1,l1,dead,fa}=%b expected %b", mon_cyc, a, e);
        end
      end
    end
  end

  // Shoot-through guard on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((leg0_hi && leg0_lo) || (leg1_hi && leg1_lo)) begin
        errors++;
        $display("FAIL shoot_through: hi0=%b lo0=%b hi1=%b lo1=%b required no pair both 1",
                 leg0_hi, leg0_lo, leg1_hi, leg1_lo);
      end
    end
  end

  task automatic load_dt(input int v);
    deadtime = 8'(v); deadtime_load = 1'b1;
    tick();
    deadtime_load = 1'b0;
  endtask

  // Edges until the selected leg-0 gate turns on (bounded).
  task automatic edges_until(input bit want_hi, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((want_hi && !leg0_hi) || (!want_hi && !leg0_lo)) && n < 60);
  endtask

  initial begin
    int  n;
    bit  cmd_r[2];
    bit  en_r[2];
    int  hold[2];
    int  en_off[2];
    int  fcnt;
    bit  ld_r, fin_r, clr_r;
    int  dt_r;

    // Reset state.
    repeat (3) tick();
    chk("reset_gates", {leg0_hi, leg0_lo, leg1_hi, leg1_lo}, 0);
    chk("reset_dead", dead_active, 0);
    chk("reset_fault", fault_active, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_gates", {leg0_hi, leg0_lo, leg1_hi, leg1_lo}, 0);

    // Deadtime 5 on both edges; enable latency.
    load_dt(5);
    leg0_en = 1'b1;
    edges_until(1'b0, n);
    chk("en_latency", n, 6);
    leg0_cmd = 1'b1;
    tick();
    chk("lo_off_at_t", leg0_lo, 0);
    edges_until(1'b1, n);
    chk("dt5_rise", n, 5);
    repeat (35) tick();
    chk("hi_held", leg0_hi, 1);
    chk("leg1_idle", {leg1_hi, leg1_lo}, 0);
    leg0_cmd = 1'b0;
    tick();
    chk("hi_off_at_t", leg0_hi, 0);
    edges_until(1'b0, n);
    chk("dt5_fall", n, 5);

    // Short pulse with dt=10.
    load_dt(10);
    leg0_cmd = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dead_active[0]) n++;
      chk("pulse_hi_off", leg0_hi, 0);
    end
    chk("pulse_dead_cycles", n, 3);
    leg0_cmd = 1'b0;
    tick();
    chk("pulse_lo_back", leg0_lo, 1);
    chk("pulse_dead_clear", dead_active[0], 0);

    // Zero deadtime: exactly one both-off cycle.
    load_dt(0);
    leg0_cmd = 1'b1;
    tick();
    chk("dt0_rise_gap", {leg0_hi, leg0_lo}, 0);
    tick();
    chk("dt0_rise_on", leg0_hi, 1);
    leg0_cmd = 1'b0;
    tick();
    chk("dt0_fall_gap", {leg0_hi, leg0_lo}, 0);
    tick();
    chk("dt0_fall_on", leg0_lo, 1);

    // Mid-count reload does not disturb the running count.
    load_dt(8);
    leg0_cmd = 1'b1;
    tick();
    n = 0;
    do begin
      if (n == 3) begin
        deadtime = 8'd2; deadtime_load = 1'b1;
      end
      tick();
      deadtime_load = 1'b0;
      n++;
    end while (!leg0_hi && n < 60);
    chk("midload_current", n, 8);
    leg0_cmd = 1'b0;
    tick();
    edges_until(1'b0, n);
    chk("midload_next", n, 2);

    // Load coinciding with dead-state entry uses the old value.
    leg0_cmd = 1'b1; deadtime = 8'd6; deadtime_load = 1'b1;
    tick();
    deadtime_load = 1'b0;
    edges_until(1'b1, n);
    chk("load_at_entry_old", n, 2);
    leg0_cmd = 1'b0;
    tick();
    edges_until(1'b0, n);
    chk("load_at_entry_new", n, 6);
    leg0_cmd = 1'b1;
    tick();
    edges_until(1'b1, n);

    // Fault while in HI.
    fault_in = 1'b1;
    tick();
    fault_in = 1'b0;
    n = 1;
    while ((leg0_hi || leg0_lo) && n < 10) begin
      tick();
      n++;
    end
    chk("fault_within_3", (n <= 3) ? 1 : 0, 1);
    chk("fault_gates", {leg0_hi, leg0_lo}, 0);
    chk("fault_flag", fault_active, 1);
    leg0_cmd = 1'b0;
`ifdef DRV_FAULT_LATCH_EN
    fault_in = 1'b1;
    repeat (3) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_ignored", fault_active, 1);
    fault_in = 1'b0;
    repeat (3) tick();
    chk("fault_sticky", fault_active, 1);
    chk("fault_sticky_gates", {leg0_hi, leg0_lo}, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("fault_cleared", fault_active, 0);
`else
    tick();
    chk("fault_self_clear", fault_active, 0);
`endif
    edges_until(1'b0, n);
    chk("fault_recover_lo", n, 6);

    // Asynchronous reset mid-HI.
    leg0_cmd = 1'b1;
    tick();
    edges_until(1'b1, n);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gates", {leg0_hi, leg0_lo, leg1_hi, leg1_lo}, 0);
    chk("async_reset_dead", dead_active, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_dead", dead_active[0], 1);
    chk("post_reset_hi_off", leg0_hi, 0);
    tick();
    chk("post_reset_hi_on", leg0_hi, 1);

    // Randomized scoreboard run.
    rst_n = 1'b0;
    leg0_cmd = 1'b0; leg0_en = 1'b0; leg1_cmd = 1'b0; leg1_en = 1'b0;
    fault_in = 1'b0; fault_clr = 1'b0; deadtime_load = 1'b0; deadtime = '0;
    tick();
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_r[i] = 0; en_r[i] = 1; hold[i] = $urandom_range(1, 10); en_off[i] = 0;
    end
    fcnt = 0; fin_r = 0; dt_r = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (en_off[i] > 0) begin
          en_off[i]--;
          en_r[i] = (en_off[i] == 0);
        end else if ($urandom_range(0, 199) == 0) begin
          en_off[i] = $urandom_range(1, 6);
          en_r[i] = 0;
        end
        if (hold[i] == 0) begin
          cmd_r[i] = !cmd_r[i];
          hold[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 25);
        end else begin
          hold[i]--;
        end
      end
      ld_r = ($urandom_range(0, 39) == 0);
      if (ld_r) dt_r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
      if (fcnt > 0) begin
        fcnt--;
        fin_r = (fcnt != 0);
      end else if ($urandom_range(0, 299) == 0) begin
        fcnt = $urandom_range(1, 4);
        fin_r = 1;
      end
      clr_r = ($urandom_range(0, 49) == 0);
      leg0_cmd = cmd_r[0]; leg0_en = en_r[0];
      leg1_cmd = cmd_r[1]; leg1_en = en_r[1];
      deadtime_load = ld_r; deadtime = 8'(dt_r);
      fault_in = fin_r; fault_clr = clr_r;
      model_step(cmd_r[0], en_r[0], cmd_r[1], en_r[1], ld_r, dt_r, fin_r, clr_r);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
